// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - seven-segment glyph constants shared by the scan driver and decoder
// Purpose: active-low segment patterns (bit7..bit0 = a,b,c,d,e,f,g,dp),
//          the blank pattern, binary-mode glyphs and segment bit indices.
// Ports:   none (package).
package seg7_pkg;

   localparam int SEG_A  = 7;
   localparam int SEG_B  = 6;
   localparam int SEG_C  = 5;
   localparam int SEG_D  = 4;
   localparam int SEG_E  = 3;
   localparam int SEG_F  = 2;
   localparam int SEG_G  = 1;
   localparam int SEG_DP = 0;

   localparam logic [7:0] SEG_BLANK    = 8'hFF;
   localparam logic [7:0] SEG_BIN_ZERO = 8'h03;
   localparam logic [7:0] SEG_BIN_ONE  = 8'h9F;

   // Entry n is the glyph for nibble value n (entry 0 is the rightmost element).
   localparam logic [15:0][7:0] SEG_HEX = {
      8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
      8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
   };

   typedef enum logic {
      MODE_BIN = 1'b0,
      MODE_HEX = 1'b1
   } disp_mode_e;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational nibble-to-segment decoder
// Purpose: map one digit value to its active-low segment pattern.
// Ports:   value   - 4-bit digit value
//          mode    - 0 = binary (nibble LSB selects 0/1 glyph), 1 = hex
//          dp      - 1 forces the decimal point segment on
//          pattern - 8-bit active-low segment pattern
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] value,
   input  logic       mode,
   input  logic       dp,
   output logic [7:0] pattern
);

   always_comb begin
      if (disp_mode_e'(mode) == MODE_HEX) begin
         pattern = SEG_HEX[value];
      end else begin
         pattern = value[0] ? SEG_BIN_ONE : SEG_BIN_ZERO;
      end
      if (dp) begin
         pattern[SEG_DP] = 1'b0;
      end
   end

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed seven-segment scan driver with shadowed display inputs
// Purpose: time-multiplexes NUM_DIGITS digits, one slot of SCAN_DIV clocks each.
//          Optional blink feature is compiled in with macro SEG_SCAN_BLINK_EN.
// Ports:   clk, rst_n (async, active-low)
//          en          - scan enable; when low the display is dark and scanning holds
//          load        - strobe capturing mode/data_in/dp_in/blank_in into the shadow
//          mode        - 0 = binary digits, 1 = hex digits
//          data_in     - nibble per digit, digit d at [4d+3:4d]
//          dp_in       - per-digit decimal point request
//          blank_in    - per-digit blank mask
//          blink_mask  - per-digit blink enable (SEG_SCAN_BLINK_EN only)
//          sel         - one-hot active-low digit select (registered)
//          seg         - active-low segments a..g,dp (registered)
//          load_ack    - pulse the cycle after load is sampled
//          frame_start - pulse when the digit index wraps to 0
module seg_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000
`ifdef SEG_SCAN_BLINK_EN
   ,
   parameter int BLINK_DIV  = 64
`endif
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    load,
   input  logic                    mode,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
`ifdef SEG_SCAN_BLINK_EN
   input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
   output logic [NUM_DIGITS-1:0]   sel,
   output logic [7:0]              seg,
   output logic                    load_ack,
   output logic                    frame_start
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

   logic [CW-1:0]           cnt;
   logic [IW-1:0]           idx;
   logic [4*NUM_DIGITS-1:0] sh_data;
   logic                    sh_mode;
   logic [NUM_DIGITS-1:0]   sh_dp;
   logic [NUM_DIGITS-1:0]   sh_blank;

   logic                    tick;
   logic                    wrap;
   logic [3:0]              cur_val;
   logic                    cur_dp;
   logic                    cur_blank;
   logic                    cur_off;
   logic [NUM_DIGITS-1:0]   next_sel;
   logic [7:0]              dec_seg;

`ifdef SEG_SCAN_BLINK_EN
   localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [FW-1:0] LAST_FRAME = FW'(BLINK_DIV - 1);

   logic [FW-1:0]           frame_cnt;
   logic                    phase;
   logic                    cur_blink;
`endif

   assign tick = en && (cnt == LAST_CNT);
   assign wrap = (idx == LAST_IDX);

   // Select the digit currently addressed by idx; the outputs registered on
   // tick therefore show this digit, and idx moves on in the same edge.
   always_comb begin
      cur_val   = 4'h0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      next_sel  = '1;
`ifdef SEG_SCAN_BLINK_EN
      cur_blink = 1'b0;
`endif
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (idx == IW'(d)) begin
            cur_val     = sh_data[4*d +: 4];
            cur_dp      = sh_dp[d];
            cur_blank   = sh_blank[d];
            next_sel[d] = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
            cur_blink   = blink_mask[d];
`endif
         end
      end
   end

`ifdef SEG_SCAN_BLINK_EN
   assign cur_off = cur_blank | (phase & cur_blink);
`else
   assign cur_off = cur_blank;
`endif

   seg7_decode u_decode (
      .value   (cur_val),
      .mode    (sh_mode),
      .dp      (cur_dp),
      .pattern (dec_seg)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         idx         <= '0;
         sh_data     <= '0;
         sh_mode     <= 1'b0;
         sh_dp       <= '0;
         sh_blank    <= '0;
         sel         <= '1;
         seg         <= SEG_BLANK;
         load_ack    <= 1'b0;
         frame_start <= 1'b0;
`ifdef SEG_SCAN_BLINK_EN
         frame_cnt   <= '0;
         phase       <= 1'b0;
`endif
      end else begin
         load_ack    <= load;
         frame_start <= 1'b0;

         // Shadow capture happens after the display sampled the old shadow
         // in this edge, so a load coinciding with tick shows next slot.
         if (load) begin
            sh_data  <= data_in;
            sh_mode  <= mode;
            sh_dp    <= dp_in;
            sh_blank <= blank_in;
         end

         if (!en) begin
            sel <= '1;
            seg <= SEG_BLANK;
         end else begin
            cnt <= (cnt == LAST_CNT) ? '0 : cnt + CW'(1);
            if (tick) begin
               sel         <= next_sel;
               seg         <= cur_off ? SEG_BLANK : dec_seg;
               idx         <= wrap ? '0 : idx + IW'(1);
               frame_start <= wrap;
`ifdef SEG_SCAN_BLINK_EN
               if (wrap) begin
                  if (frame_cnt == LAST_FRAME) begin
                     frame_cnt <= '0;
                     phase     <= ~phase;
                  end else begin
                     frame_cnt <= frame_cnt + FW'(1);
                  end
               end
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - self-checking bench for seg_scan_driver
module tb_seg_scan_driver;

   localparam int N  = 4;
   localparam int SD = 4;
   localparam int BD = 2;

   logic          clk;
   logic          rst_n;
   logic          en;
   logic          load;
   logic          mode;
   logic [4*N-1:0] data_in;
   logic [N-1:0]  dp_in;
   logic [N-1:0]  blank_in;
`ifdef SEG_SCAN_BLINK_EN
   logic [N-1:0]  blink_mask;
`endif
   logic [N-1:0]  sel;
   logic [7:0]    seg;
   logic          load_ack;
   logic          frame_start;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state: counts of enabled cycles and ticks since reset.
   int            en_cycles;
   int            ticks;
   logic [15:0]   m_data;
   logic          m_mode;
   logic [3:0]    m_dp;
   logic [3:0]    m_blank;
   logic [3:0]    exp_sel;
   logic [7:0]    exp_seg;
   logic          exp_ack;
   logic          exp_fs;

   logic [7:0] hex_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

   seg_scan_driver #(
      .NUM_DIGITS (N),
      .SCAN_DIV   (SD)
`ifdef SEG_SCAN_BLINK_EN
      ,
      .BLINK_DIV  (BD)
`endif
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .load        (load),
      .mode        (mode),
      .data_in     (data_in),
      .dp_in       (dp_in),
      .blank_in    (blank_in),
`ifdef SEG_SCAN_BLINK_EN
      .blink_mask  (blink_mask),
`endif
      .sel         (sel),
      .seg         (seg),
      .load_ack    (load_ack),
      .frame_start (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] glyph(input int d);
      logic [3:0] nib;
      logic [7:0] g;
      logic       off;
      nib = m_data[4*d +: 4];
      off = m_blank[d];
`ifdef SEG_SCAN_BLINK_EN
      if ((((ticks / N) / BD) % 2) == 1 && blink_mask[d]) off = 1'b1;
`endif
      if (off) return 8'hFF;
      g = m_mode ? hex_tab[nib] : (nib[0] ? 8'h9F : 8'h03);
      if (m_dp[d]) g[0] = 1'b0;
      return g;
   endfunction

   task automatic model_reset();
      en_cycles = 0;
      ticks     = 0;
      m_data    = '0;
      m_mode    = 1'b0;
      m_dp      = '0;
      m_blank   = '0;
      exp_sel   = 4'hF;
      exp_seg   = 8'hFF;
      exp_ack   = 1'b0;
      exp_fs    = 1'b0;
   endtask

   // One clock: predict from current inputs, clock, then compare everything.
   task automatic cycle();
      int d;
      exp_ack = load;
      exp_fs  = 1'b0;
      if (!en) begin
         exp_sel = 4'hF;
         exp_seg = 8'hFF;
      end else begin
         if ((en_cycles % SD) == SD - 1) begin
            d       = ticks % N;
            exp_sel = ~(4'b0001 << d);
            exp_seg = glyph(d);
            exp_fs  = (d == N - 1);
            ticks++;
         end
         en_cycles++;
      end
      if (load) begin
         m_data  = data_in;
         m_mode  = mode;
         m_dp    = dp_in;
         m_blank = blank_in;
      end
      @(posedge clk);
      #1;
      chk("sel", sel, exp_sel);
      chk("seg", seg, exp_seg);
      chk("load_ack", load_ack, exp_ack);
      chk("frame_start", frame_start, exp_fs);
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   // Clock until the next edge is a tick (requires en=1).
   task automatic advance();
      for (int k = 0; k < 64 && (en_cycles % SD) != SD - 1; k++) cycle();
   endtask

   initial begin
      rst_n    = 1'b0;
      en       = 1'b0;
      load     = 1'b0;
      mode     = 1'b0;
      data_in  = '0;
      dp_in    = '0;
      blank_in = '0;
`ifdef SEG_SCAN_BLINK_EN
      blink_mask = '0;
`endif
      model_reset();
      @(posedge clk);
      #1;
      chk("rst_sel", sel, 4'hF);
      chk("rst_seg", seg, 8'hFF);
      chk("rst_ack", load_ack, 1'b0);
      chk("rst_fs", frame_start, 1'b0);
      rst_n = 1'b1;

      // Hex scan, load accepted while disabled.
      load = 1'b1; mode = 1'b1; data_in = 16'h1A3F;
      cycle();
      load = 1'b0; en = 1'b1;
      run(3);
      chk("pre_first_tick", {sel, seg}, {4'hF, 8'hFF});
      cycle(); chk("hex_d0", {sel, seg}, {4'hE, 8'h71});
      run(3); cycle(); chk("hex_d1", {sel, seg}, {4'hD, 8'h0D});
      run(3); cycle(); chk("hex_d2", {sel, seg}, {4'hB, 8'h11});
      run(3); cycle(); chk("hex_d3", {sel, seg}, {4'h7, 8'h9F});
      chk("hex_wrap_fs", frame_start, 1'b1);

      // Binary mode.
      load = 1'b1; mode = 1'b0; data_in = 16'h0001;
      cycle();
      load = 1'b0;
      advance(); cycle(); chk("bin_d0", {sel, seg}, {4'hE, 8'h9F});
      advance(); cycle(); chk("bin_d1", {sel, seg}, {4'hD, 8'h03});
      advance(); cycle(); chk("bin_d2", {sel, seg}, {4'hB, 8'h03});
      advance(); cycle(); chk("bin_d3", {sel, seg}, {4'h7, 8'h03});

      // Load coincident with tick: old value now, new value next slot.
      advance();
      load = 1'b1; mode = 1'b1; data_in = 16'h8880;
      cycle();
      load = 1'b0;
      chk("ldtick_old", {sel, seg}, {4'hE, 8'h9F});
      chk("ldtick_ack1", load_ack, 1'b1);
      cycle();
      chk("ldtick_ack0", load_ack, 1'b0);
      advance(); cycle(); chk("ldtick_new", {sel, seg}, {4'hD, 8'h01});

      // Decimal point, blank and enable hold.
      load = 1'b1; data_in = 16'h1234; dp_in = 4'b0010; blank_in = 4'b1000;
      cycle();
      load = 1'b0;
      advance(); cycle();
      advance(); cycle(); chk("blank_d3", {sel, seg}, {4'h7, 8'hFF});
      advance(); cycle(); chk("d0_plain", {sel, seg}, {4'hE, 8'h99});
      advance(); cycle(); chk("dp_d1", {sel, seg}, {4'hD, 8'h0C});
      run(1);
      en = 1'b0;
      run(10);
      chk("dis_sel", sel, 4'hF);
      chk("dis_seg", seg, 8'hFF);
      en = 1'b1;
      advance(); cycle(); chk("resume_d2", sel, 4'hB);

      // Back-to-back loads, each acknowledged.
      load = 1'b1; data_in = 16'h5555; dp_in = 4'b0000; blank_in = 4'b0000;
      cycle();
      data_in = 16'hCDEF;
      cycle();
      load = 1'b0;
      chk("b2b_ack2", load_ack, 1'b1);
      cycle();

`ifdef SEG_SCAN_BLINK_EN
      // Blink digit 0 over several frames; model tracks the phase.
      blink_mask = 4'b0001;
      for (int f = 0; f < 6 * N; f++) begin
         advance();
         cycle();
      end
`endif

      // Randomized traffic.
      for (int k = 0; k < 800; k++) begin
         en       = ($urandom_range(0, 9) != 0);
         load     = ($urandom_range(0, 7) == 0);
         mode     = $urandom_range(0, 1);
         data_in  = $urandom;
         dp_in    = $urandom;
         blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
`ifdef SEG_SCAN_BLINK_EN
         blink_mask = $urandom;
`endif
         cycle();
      end
      load = 1'b0;
      en   = 1'b1;
      run(5);

      // Asynchronous reset mid-scan, then first digit after release.
      rst_n = 1'b0;
      #1;
      chk("async_sel", sel, 4'hF);
      chk("async_seg", seg, 8'hFF);
      chk("async_ack", load_ack, 1'b0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      advance();
      cycle();
      chk("first_after_rst", {sel, seg}, {4'hE, 8'h03});
      run(8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 50000: clock cycles per digit slot, legal range 2..2^20.
REQ-003 Parameter BLINK_DIV, default 64: complete scan frames per blink half-period; used only when SEG_SCAN_BLINK_EN is defined.
REQ-004 Port clk, input, 1: single clock; every register is on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port en, input, 1: scan enable.
REQ-007 Port load, input, 1: one-cycle strobe that captures the display inputs into the shadow registers.
REQ-008 Port mode, input, 1: 0 = binary digit mode, 1 = hex mode; captured on load.
REQ-009 Port data_in, input, 4*NUM_DIGITS: digit d uses nibble [4d+3:4d]; captured on load.
REQ-010 Port dp_in, input, NUM_DIGITS: per-digit decimal-point request; captured on load.
REQ-011 Port blank_in, input, NUM_DIGITS: per-digit blank mask; captured on load.
REQ-012 Port blink_mask, input, NUM_DIGITS: per-digit blink enable; the port exists only when SEG_SCAN_BLINK_EN is defined.
REQ-013 Port sel, output, NUM_DIGITS: digit select, one-hot, active-low.
REQ-014 Port seg, output, 8: segment drive, active-low; bit7..bit0 = a,b,c,d,e,f,g,dp.
REQ-015 Port load_ack, output, 1: one-cycle pulse in the cycle after load is sampled.
REQ-016 Port frame_start, output, 1: one-cycle pulse when the digit index wraps to 0.

Function
REQ-017 The prescaler SHALL count 0..SCAN_DIV-1 while en=1, wrap to 0, and assert an internal tick in the cycle it equals SCAN_DIV-1.
REQ-018 On tick, the digit index SHALL advance by one; after NUM_DIGITS-1 it SHALL wrap to 0 and pulse frame_start in the same cycle the registered outputs update.
REQ-019 sel and seg SHALL be registered and update exactly one cycle after tick; sel[idx]=0 and all other sel bits =1.
REQ-020 The display SHALL read only the shadow registers; when load and tick coincide, the digit taking effect SHALL use the pre-load shadow, and the new shadow SHALL be visible from the next tick.
REQ-021 Hex mode SHALL decode nibbles 0..F to 03,9F,25,0D,99,49,41,1F,01,09,11,C1,63,85,61,71 (hex).
REQ-022 Binary mode SHALL show 03 if data bit d (bit 4d of data_in, i.e. the nibble LSB) is 0, and 9F if it is 1.
REQ-023 If the digit's shadow dp bit is 1, seg[0] SHALL be forced to 0.
REQ-024 If the digit's shadow blank bit is 1, seg SHALL be 8'hFF with dp suppressed.
REQ-025 While en=0, the prescaler and index SHALL hold, sel SHALL be all ones, and seg SHALL be 8'hFF from the next cycle; on re-enable, scanning SHALL resume from the held index and count.
REQ-026 load SHALL be accepted whether or not en is 1; back-to-back loads SHALL each be captured and each acknowledged.

Reset
REQ-027 rst_n=0 SHALL asynchronously clear the prescaler, index and all shadow registers, set sel to all ones and seg to 8'hFF, and clear load_ack, frame_start and the blink phase.
REQ-028 The first digit-0 drive after reset release SHALL occur one cycle after the first tick.

Configuration
REQ-029 With macro SEG_SCAN_BLINK_EN defined, a blink phase bit SHALL toggle every BLINK_DIV frame_start pulses, and while it is 1, digits whose blink_mask bit is 1 SHALL be blanked as in REQ-024.
REQ-030 Without SEG_SCAN_BLINK_EN, blink_mask, the phase logic and BLINK_DIV SHALL be absent and have no effect.

Structure
REQ-031 Package seg7_pkg SHALL hold the 16-entry hex segment constants, SEG_BLANK=8'hFF, the binary-mode glyph constants and the segment bit-index constants.
REQ-032 Sub-module seg7_decode SHALL be purely combinational and map a 4-bit value, mode and dp to an 8-bit pattern; seg_scan_driver SHALL instantiate it once.

Verification (NUM_DIGITS=4, SCAN_DIV=4)
REQ-033 Reset: rst_n=0 mid-scan -> sel=4'hF and seg=8'hFF immediately, without waiting for a clock edge.
REQ-034 Hex scan: load data_in=16'h1A3F, mode=1 -> seg sequence F:71, 3:0D, A:11, 1:9F paired with sel E,D,B,7, each held 4 cycles, and frame_start on the wrap.
REQ-035 Binary mode: data_in=16'h0001 (digit 0 nibble LSB = 1), mode=0 -> digit0 shows 9F and digits 1..3 show 03.
REQ-036 load coincident with tick -> the current slot shows the old value, the next slot shows the new value, and load_ack is 1 for exactly one cycle.
REQ-037 dp_in=4'b0010, blank_in=4'b1000 -> digit1 has seg[0]=0 and digit3 shows FF; then en=0 for 10 cycles -> sel=F, and on re-enable the index resumes.
REQ-038 SEG_SCAN_BLINK_EN with BLINK_DIV=2 and blink_mask=4'b0001 -> digit0 is blanked on alternating 2-frame intervals and the other digits are unaffected.
